// File: rtl/md_bus_share.sv
// Shared-bus owner sequencer: round-robin arbitration of N sources onto one
// bidirectional bus with turnaround gaps, hold limit, contention flag and test override.
module md_bus_share #(
  parameter int W        = 16,
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int HOLD_MAX = 64,
  localparam int OW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic            MCLK,
  input  logic            SRES,
  input  logic [N-1:0]    REQ,
  input  logic [N*W-1:0]  SRC_o,
  input  logic [W-1:0]    BUS_i,
  input  logic            TEST_EN,
  input  logic [OW-1:0]   TEST_OWN,
  input  logic            CLR,
  output logic [W-1:0]    BUS_o,
  output logic            BUS_d,
  output logic [N-1:0]    GNT,
  output logic [OW-1:0]   OWNER,
  output logic            TIMEOUT,
  output logic            CONT
);

  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int GW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_OWN} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   ptr, ptr_nxt;
  logic [N-1:0]    gnt, gnt_nxt;
  logic            bus_d, bus_d_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic            first_own, first_nxt;
  logic            tmode, tmode_nxt;
  logic            timeout, timeout_nxt;
  logic            cont, cont_nxt;

  logic [W-1:0]    src_w [N];
  logic [OW:0]     pick;
  logic            arb_hit;
  logic [OW-1:0]   arb_idx;
  logic            others_pending;
  logic            hold_sat;
  logic            preempt;
  logic            own_end;

  // First set request strictly after base, wrapping modulo N; MSB flags a hit.
  function automatic logic [OW:0] rr_pick(input logic [N-1:0] req, input logic [OW-1:0] base);
    logic [OW:0] r;
    r = '0;
    for (int i = N; i >= 1; i--) begin
      int j;
      j = (int'(base) + i) % N;
      if (req[OW'(j)]) r = {1'b1, OW'(j)};
    end
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_src
    assign src_w[g] = SRC_o[g*W +: W];
  end

  assign BUS_o   = bus_d ? '0 : src_w[owner];
  assign BUS_d   = bus_d;
  assign GNT     = gnt;
  assign OWNER   = owner;
  assign TIMEOUT = timeout;
  assign CONT    = cont;

  always_comb begin
    pick    = rr_pick(REQ, ptr);
    arb_hit = TEST_EN ? (int'(TEST_OWN) < N) : pick[OW];
    arb_idx = TEST_EN ? TEST_OWN : pick[OW-1:0];
  end

  // The limit only bites when someone else is waiting; otherwise the count saturates.
  assign others_pending = |(REQ & ~gnt);
  assign hold_sat       = (HOLD_MAX == 0) || (hold_cnt == HW'(HOLD_MAX));
  assign preempt        = !tmode && (HOLD_MAX != 0) && (hold_cnt == HW'(HOLD_MAX)) && others_pending;
  assign own_end        = tmode ? (!TEST_EN || (TEST_OWN != owner))
                                : (!REQ[owner] || TEST_EN || preempt);

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state     <= S_IDLE;
      owner     <= '0;
      ptr       <= '0;
      gnt       <= '0;
      bus_d     <= 1'b1;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      first_own <= 1'b0;
      tmode     <= 1'b0;
      timeout   <= 1'b0;
      cont      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      bus_d     <= bus_d_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      first_own <= first_nxt;
      tmode     <= tmode_nxt;
      timeout   <= timeout_nxt;
      cont      <= cont_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    bus_d_nxt   = bus_d;
    hold_nxt    = hold_cnt;
    gap_nxt     = gap_cnt;
    first_nxt   = first_own;
    tmode_nxt   = tmode;
    timeout_nxt = 1'b0;
    cont_nxt    = cont & ~CLR;
    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          state_nxt = S_OWN;
          owner_nxt = arb_idx;
          gnt_nxt   = N'(1) << arb_idx;
          bus_d_nxt = 1'b0;
          hold_nxt  = '0;
          first_nxt = 1'b1;
          tmode_nxt = TEST_EN;
          if (!TEST_EN) ptr_nxt = arb_idx;
        end
      end
      S_OWN: begin
        // Read-back on the first owned cycle is still settling, so it is not judged.
        if (!first_own && (BUS_i != BUS_o)) cont_nxt = 1'b1;
        if (own_end) begin
          state_nxt   = (TURN == 0) ? S_IDLE : S_GAP;
          gnt_nxt     = '0;
          bus_d_nxt   = 1'b1;
          gap_nxt     = '0;
          timeout_nxt = preempt;
        end else begin
          first_nxt = 1'b0;
          if (!hold_sat) hold_nxt = hold_cnt + HW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(TURN - 1)) state_nxt = S_IDLE;
        else gap_nxt = gap_cnt + GW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_bus_share.sv
// Bench for md_bus_share: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of owner/gap/round-robin rules.
module tb_md_bus_share;
  localparam int W = 16, N = 4, TURN = 1, HOLD = 8, OW = 2;

  logic MCLK = 1'b0;
  logic SRES = 1'b1;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] SRC_o;
  logic [W-1:0]   BUS_i;
  logic           TEST_EN;
  logic [OW-1:0]  TEST_OWN;
  logic           CLR;
  logic [W-1:0]   BUS_o;
  logic           BUS_d;
  logic [N-1:0]   GNT;
  logic [OW-1:0]  OWNER;
  logic           TIMEOUT, CONT;

  logic [4:0]   req5;
  logic [5*W-1:0] src5;
  logic [W-1:0] busi5, buso5;
  logic         ten5, clr5, busd5, to5, cont5;
  logic [2:0]   town5, own5;
  logic [4:0]   gnt5;

  int errors = 0;
  int checks = 0;

  bit m_own, m_test, m_first, m_cont, m_to;
  int m_owner, m_ptr, m_wait, m_held;

  md_bus_share #(.W(W), .N(N), .TURN(TURN), .HOLD_MAX(HOLD)) dut (
    .MCLK(MCLK), .SRES(SRES), .REQ(REQ), .SRC_o(SRC_o), .BUS_i(BUS_i),
    .TEST_EN(TEST_EN), .TEST_OWN(TEST_OWN), .CLR(CLR), .BUS_o(BUS_o),
    .BUS_d(BUS_d), .GNT(GNT), .OWNER(OWNER), .TIMEOUT(TIMEOUT), .CONT(CONT));

  md_bus_share #(.W(W), .N(5), .TURN(0), .HOLD_MAX(2)) dut5 (
    .MCLK(MCLK), .SRES(SRES), .REQ(req5), .SRC_o(src5), .BUS_i(busi5),
    .TEST_EN(ten5), .TEST_OWN(town5), .CLR(clr5), .BUS_o(buso5),
    .BUS_d(busd5), .GNT(gnt5), .OWNER(own5), .TIMEOUT(to5), .CONT(cont5));

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] src_of(input int i);
    return W'(SRC_o >> (i * W));
  endfunction

  function automatic logic [W-1:0] m_bus();
    return m_own ? src_of(m_owner) : '0;
  endfunction

  task automatic model_reset();
    m_own = 0; m_test = 0; m_first = 0; m_cont = 0; m_to = 0;
    m_owner = 0; m_ptr = 0; m_wait = 0; m_held = 0;
  endtask

  task automatic model_grant(input int idx, input bit t);
    m_own = 1; m_owner = idx; m_held = 0; m_first = 1; m_test = t;
  endtask

  // One rising edge of the model, evaluated on the inputs held across that edge.
  task automatic model_step();
    bit set_c, fin, pre, found;
    int r;
    set_c = 0; fin = 0; pre = 0; found = 0;
    r = int'(REQ);
    m_to = 0;
    if (m_own) begin
      if (!m_first && (BUS_i !== src_of(m_owner))) set_c = 1;
      if (m_test) fin = !TEST_EN || (int'(TEST_OWN) != m_owner);
      else begin
        pre = (m_held == HOLD) && ((r & ~(1 << m_owner)) != 0);
        fin = (((r >> m_owner) & 1) == 0) || TEST_EN || pre;
      end
      m_to = pre;
      if (fin) begin
        m_own = 0;
        m_wait = TURN;
      end else begin
        m_first = 0;
        if (m_held < HOLD) m_held++;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (TEST_EN) begin
      if (int'(TEST_OWN) < N) model_grant(int'(TEST_OWN), 1);
    end else begin
      for (int i = 1; i <= N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (!found && (((r >> j) & 1) == 1)) begin
          found = 1;
          model_grant(j, 0);
          m_ptr = j;
        end
      end
    end
    m_cont = set_c || (m_cont && !CLR);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bus_d"}, BUS_d, !m_own);
    chk({tag, ".gnt"}, GNT, m_own ? (64'd1 << m_owner) : 64'd0);
    chk({tag, ".owner"}, OWNER, m_owner);
    chk({tag, ".timeout"}, TIMEOUT, m_to);
    chk({tag, ".cont"}, CONT, m_cont);
    chk({tag, ".bus_o"}, BUS_o, m_bus());
  endtask

  task automatic tick(input string tag);
    @(posedge MCLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    #3;
    SRES = 1'b0;
    model_reset();
    REQ = '0; TEST_EN = 0; TEST_OWN = '0; CLR = 0; BUS_i = '0;
    #1;
    chk("arst.bus_d", BUS_d, 1);
    chk("arst.gnt", GNT, 0);
    chk("arst.bus_o", BUS_o, 0);
    chk("arst.cont", CONT, 0);
    chk("arst.timeout", TIMEOUT, 0);
    #2;
    SRES = 1'b1;
  endtask

  initial begin
    int order[$];
    int gaps[$];
    int exp_rr[5] = '{1, 2, 3, 0, 1};
    logic [4:0] exp5[9] = '{5'd2, 5'd2, 5'd2, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd2};
    int ocnt, rel, tos;
    bit pd;

    REQ = '0; SRC_o = '0; BUS_i = '0; TEST_EN = 0; TEST_OWN = '0; CLR = 0;
    req5 = '0; src5 = '0; busi5 = '0; ten5 = 0; town5 = '0; clr5 = 0;
    model_reset();
    #1 SRES = 1'b0;
    #1;
    chk("rst.bus_d", BUS_d, 1);
    chk("rst.gnt", GNT, 0);
    chk("rst.owner", OWNER, 0);
    chk("rst.timeout", TIMEOUT, 0);
    chk("rst.cont", CONT, 0);
    chk("rst.bus_o", BUS_o, 0);
    chk("rst5.bus_d", busd5, 1);
    chk("rst5.gnt", gnt5, 0);
    #10 SRES = 1'b1;

    // TURN=0, hold limit 2: sources 1 and 0 alternate with one idle cycle
    tick("idle");
    req5 = 5'b00011;
    for (int k = 0; k < 9; k++) begin
      tick("t0");
      chk("t0.gnt", gnt5, exp5[k]);
      chk("t0.bus_d", busd5, exp5[k] == 5'd0);
      chk("t0.timeout", to5, (k == 3) || (k == 7));
    end
    // Forced owner index beyond N never gets the bus
    req5 = '0; ten5 = 1; town5 = 3'd5;
    for (int k = 0; k < 5; k++) begin
      tick("tov");
      chk("tov.gnt", gnt5, 0);
      chk("tov.bus_d", busd5, 1);
    end
    ten5 = 0;

    // Round-robin with each owner dropping after 3 cycles
    REQ = '1; ocnt = 0; rel = 0; pd = 1;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick("rr");
      if (!BUS_d) begin
        if (pd) begin
          order.push_back(int'(OWNER));
          if (order.size() > 1) gaps.push_back(rel);
          rel = 0; ocnt = 0;
        end
        ocnt++;
        if (ocnt == 3) REQ[OWNER] = 1'b0;
      end else begin
        rel++;
        REQ = '1;
      end
      pd = BUS_d;
    end
    chk("rr.count", order.size(), 5);
    for (int i = 0; i < order.size(); i++) chk("rr.order", order[i], exp_rr[i]);
    for (int i = 0; i < gaps.size(); i++) chk("rr.gap", gaps[i], TURN + 1);

    // Hold limit with a competitor
    do_reset();
    REQ = 4'b0001; tos = 0;
    for (int t = 0; t < 15; t++) begin
      tick("hold");
      if (t == 1) REQ[2] = 1'b1;
      tos += int'(TIMEOUT);
      if (t <= 8) chk("hold.gnt0", GNT, 4'b0001);
      else if (t <= 10) begin
        chk("hold.rel", BUS_d, 1);
        chk("hold.to", TIMEOUT, t == 9);
      end else chk("hold.gnt2", GNT, 4'b0100);
    end
    chk("hold.pulses", tos, 1);

    // Hold limit alone: no preemption
    do_reset();
    REQ = 4'b0001;
    for (int t = 0; t < 20; t++) begin
      tick("alone");
      chk("alone.gnt", GNT, 4'b0001);
      chk("alone.to", TIMEOUT, 0);
    end

    // Test override while source 1 owns
    do_reset();
    REQ = 4'b0010;
    SRC_o = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    BUS_i = 16'hB001;
    tick("ovr"); chk("ovr.gnt1", GNT, 4'b0010);
    tick("ovr");
    TEST_EN = 1; TEST_OWN = 2'd3;
    tick("ovr"); chk("ovr.rel", BUS_d, 1); chk("ovr.relg", GNT, 0);
    tick("ovr"); chk("ovr.gap", BUS_d, 1);
    tick("ovr");
    chk("ovr.owner", OWNER, 3);
    chk("ovr.bus_o", BUS_o, 16'hD003);
    chk("ovr.gnt3", GNT, 4'b1000);
    BUS_i = 16'hD003;
    tick("ovr"); chk("ovr.keep", GNT, 4'b1000);
    TEST_EN = 0; REQ = '0;
    tick("ovr"); chk("ovr.end", BUS_d, 1);

    // Contention flag
    do_reset();
    REQ = 4'b0010;
    SRC_o = 64'h0000_0000_1234_0000;
    BUS_i = 16'h1230;
    tick("cont"); chk("cont.gnt", GNT, 4'b0010); chk("cont.bus_o", BUS_o, 16'h1234);
    tick("cont"); chk("cont.first", CONT, 0);
    BUS_i = 16'h1234;
    tick("cont"); chk("cont.match", CONT, 0);
    BUS_i = 16'h1230;
    tick("cont"); chk("cont.set", CONT, 1);
    BUS_i = 16'h1234;
    tick("cont"); chk("cont.sticky", CONT, 1);
    CLR = 1;
    tick("cont"); chk("cont.clr", CONT, 0);
    BUS_i = 16'h1230;
    tick("cont"); chk("cont.setwins", CONT, 1);
    BUS_i = 16'h1234; CLR = 0;
    tick("cont"); chk("cont.hold2", CONT, 1);

    // Async reset mid-ownership, then round-robin restarts from pointer 0
    do_reset();
    REQ = '1;
    tick("post"); chk("post.gnt", GNT, 4'b0010); chk("post.owner", OWNER, 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tick("rnd");
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) REQ[b] = ~REQ[b];
      if ($urandom_range(3) == 0) SRC_o = {$urandom, $urandom};
      if ($urandom_range(39) == 0) TEST_EN = ~TEST_EN;
      if ($urandom_range(15) == 0) TEST_OWN = OW'($urandom_range(3));
      CLR = ($urandom_range(9) == 0);
      BUS_i = m_bus() ^ (($urandom_range(11) == 0) ? W'(1 << $urandom_range(15)) : W'(0));
      #1;
      chk("rnd.pass", BUS_o, m_bus());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
